// File: rtl/lift_final_sub_pipe.sv
// Final modular-subtraction stage for the Lift/Shoup datapath.
// Computes (a - b) mod q_i over a stream of residues, where q_i comes from a
// runtime-programmable modulus table and i rotates over num_mod entries.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   cfg_we     modulus table write strobe
//   cfg_addr   table entry address (addresses >= NMOD are ignored)
//   cfg_data   modulus value to write
//   num_mod    moduli per group (0 or > NMOD means NMOD), quasi-static
//   grp_clr    synchronous pulse forcing the rotating index to 0
//   a_in       minuend residue
//   a_valid    a_in valid
//   b_in       subtrahend, presented DLY cycles after its a_in
//   out_data   (a - b) mod q_i
//   out_valid  result valid
//   out_idx    modulus index used for this result
//   out_last   result used index num_mod-1
//   out_err    an operand was >= q_i (result still computed)
module lift_final_sub_pipe #(
  parameter int W    = 30,
  parameter int NMOD = 16,
  parameter int IW   = 4,
  parameter int DLY  = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_addr,
  input  logic [W-1:0]  cfg_data,
  input  logic [IW:0]   num_mod,
  input  logic          grp_clr,
  input  logic [W-1:0]  a_in,
  input  logic          a_valid,
  input  logic [W-1:0]  b_in,
  output logic [W-1:0]  out_data,
  output logic          out_valid,
  output logic [IW-1:0] out_idx,
  output logic          out_last,
  output logic          out_err
);

  // --------------------------------------------------------------------------
  // Alignment delay: a_in/a_valid are delayed so they line up with b_in.
  // --------------------------------------------------------------------------
  logic [W-1:0] a_d;
  logic         v_d;

  if (DLY == 0) begin : g_nodly
    assign a_d = a_in;
    assign v_d = a_valid;
  end else begin : g_dly
    logic [DLY-1:0][W-1:0] a_sr;
    logic [DLY:0][W-1:0]   a_chain;
    logic [DLY-1:0]        v_sr;
    logic [DLY:0]          v_chain;

    assign a_chain = {a_sr, a_in};
    assign v_chain = {v_sr, a_valid};

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        v_sr <= '0;
      end else begin
        v_sr <= v_chain[DLY-1:0];
      end
    end

    // Data taps carry no reset; only the valid bits are meaningful.
    always_ff @(posedge clk) begin
      a_sr <= a_chain[DLY-1:0];
    end

    assign a_d = a_sr[DLY-1];
    assign v_d = v_sr[DLY-1];
  end

  // --------------------------------------------------------------------------
  // Modulus table
  // --------------------------------------------------------------------------
  logic [W-1:0] tbl [NMOD];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NMOD; i++) tbl[i] <= '0;
    end else if (cfg_we && ({1'b0, cfg_addr} < (IW+1)'(NMOD))) begin
      tbl[cfg_addr] <= cfg_data;
    end
  end

  // --------------------------------------------------------------------------
  // Rotating modulus index
  // --------------------------------------------------------------------------
  logic [IW:0]   nme;
  logic [IW-1:0] idx;
  logic [IW-1:0] cur_idx;
  logic          cur_last;
  logic [IW-1:0] idx_nxt;

  always_comb begin
    nme = num_mod;
    if (num_mod == '0 || num_mod > (IW+1)'(NMOD)) nme = (IW+1)'(NMOD);
  end

  // An index left out of range by a shrinking num_mod restarts the group at 0.
  always_comb begin
    cur_idx = idx;
    if (grp_clr || ({1'b0, idx} >= nme)) cur_idx = '0;
    cur_last = ({1'b0, cur_idx} == (nme - (IW+1)'(1)));
  end

  always_comb begin
    idx_nxt = idx;
    if (v_d) begin
      idx_nxt = cur_last ? '0 : cur_idx + IW'(1);
    end else if (grp_clr) begin
      idx_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idx <= '0;
    else      idx <= idx_nxt;
  end

  // --------------------------------------------------------------------------
  // Stage 1: raw difference, modulus lookup, range check
  // --------------------------------------------------------------------------
  logic [W-1:0]  q_cur;
  logic [W:0]    diff;
  logic          err_cur;

  logic [W:0]    s1_diff;
  logic [W-1:0]  s1_q;
  logic [IW-1:0] s1_idx;
  logic          s1_last;
  logic          s1_err;
  logic          s1_valid;

  always_comb begin
    q_cur   = tbl[cur_idx];
    diff    = {1'b0, a_d} - {1'b0, b_in};
    err_cur = (a_d >= q_cur) | (b_in >= q_cur);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_diff  <= '0;
      s1_q     <= '0;
      s1_idx   <= '0;
      s1_last  <= 1'b0;
      s1_err   <= 1'b0;
    end else begin
      s1_valid <= v_d;
      if (v_d) begin
        s1_diff <= diff;
        s1_q    <= q_cur;
        s1_idx  <= cur_idx;
        s1_last <= cur_last;
        s1_err  <= err_cur;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: add q back when the subtraction borrowed
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= s1_diff[W] ? s1_diff[W-1:0] + s1_q : s1_diff[W-1:0];
        out_idx  <= s1_idx;
        out_last <= s1_last;
        out_err  <= s1_err;
      end
    end
  end

endmodule

// File: tb/tb_lift_final_sub_pipe.sv
module tb_lift_final_sub_pipe;

  localparam int W    = 30;
  localparam int NMOD = 16;
  localparam int IW   = 4;
  localparam int DLY  = 3;

  logic          clk;
  logic          rst;
  logic          cfg_we;
  logic [IW-1:0] cfg_addr;
  logic [W-1:0]  cfg_data;
  logic [IW:0]   num_mod;
  logic          grp_clr;
  logic [W-1:0]  a_in;
  logic          a_valid;
  logic [W-1:0]  b_in;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          out_err;

  lift_final_sub_pipe #(.W(W), .NMOD(NMOD), .IW(IW), .DLY(DLY)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .num_mod(num_mod), .grp_clr(grp_clr),
    .a_in(a_in), .a_valid(a_valid), .b_in(b_in),
    .out_data(out_data), .out_valid(out_valid), .out_idx(out_idx),
    .out_last(out_last), .out_err(out_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit           v;
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           clr;
  } smp_t;

  typedef struct {
    longint data;
    int     idx;
    bit     last;
    bit     err;
    longint cyc;
  } exp_t;

  smp_t   pend[$];
  exp_t   sb[$];
  longint tbl_m [NMOD];
  int     idx_m;
  int     n_tests = 0;
  int     n_fail  = 0;

  localparam longint MASK = (longint'(1) << W) - 1;

  function automatic int eff_nmod();
    int n;
    n = int'(num_mod);
    if (n == 0 || n > NMOD) n = NMOD;
    return n;
  endfunction

  // Reference: (a - b) mod q with q added back on borrow, truncated to W bits.
  function automatic void model(input smp_t s);
    exp_t   e;
    int     n;
    int     use_idx;
    longint q;
    longint r;
    n       = eff_nmod();
    use_idx = (s.clr || idx_m >= n) ? 0 : idx_m;
    q       = tbl_m[use_idx];
    r       = longint'(s.a) - longint'(s.b);
    if (r < 0) r = r + q;
    e.data  = r & MASK;
    e.idx   = use_idx;
    e.last  = (use_idx == n - 1);
    e.err   = (longint'(s.a) >= q) || (longint'(s.b) >= q);
    e.cyc   = cyc + 2;
    sb.push_back(e);
    idx_m   = (use_idx + 1) % n;
  endfunction

  task automatic pend_init();
    smp_t z;
    z = '{v: 1'b0, a: '0, b: '0, clr: 1'b0};
    pend.delete();
    for (int i = 0; i < DLY; i++) pend.push_back(z);
  endtask

  // One cycle of stimulus. A new sample (a now, b/clr DLY cycles later) plus an
  // immediate config write.
  task automatic tick(input bit av, input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit clr, input bit we, input logic [IW-1:0] addr,
                      input logic [W-1:0] data);
    smp_t s;
    smp_t al;
    s  = '{v: av, a: a, b: b, clr: clr};
    pend.push_back(s);
    al = pend.pop_front();
    a_valid  = av;
    a_in     = a;
    b_in     = al.b;
    grp_clr  = al.clr;
    cfg_we   = we;
    cfg_addr = addr;
    cfg_data = data;
    if (al.v) model(al);
    else if (al.clr) idx_m = 0;
    if (we && int'(addr) < NMOD) tbl_m[addr] = longint'(data);
    @(posedge clk);
    #1;
  endtask

  task automatic smp(input logic [W-1:0] a, input logic [W-1:0] b, input bit clr);
    tick(1'b1, a, b, clr, 1'b0, '0, '0);
  endtask

  task automatic idle();
    tick(1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic wr(input logic [IW-1:0] addr, input logic [W-1:0] data);
    tick(1'b0, '0, '0, 1'b0, 1'b1, addr, data);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    sb.delete();
    pend_init();
    idx_m = 0;
    for (int i = 0; i < NMOD; i++) tbl_m[i] = 0;
    for (int i = 0; i < n; i++) begin
      a_valid  = 1'($urandom);
      a_in     = W'($urandom);
      b_in     = W'($urandom);
      grp_clr  = 1'($urandom);
      cfg_we   = 1'($urandom);
      cfg_addr = IW'($urandom);
      cfg_data = W'($urandom);
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_idx !== '0 ||
          out_last !== 1'b0 || out_err !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: got valid=%0b data=%0d idx=%0d last=%0b err=%0b, want all 0",
                 out_valid, out_data, out_idx, out_last, out_err);
      end
      @(posedge clk);
      #1;
    end
    rst      = 1'b1;
    a_valid  = 1'b0;
    grp_clr  = 1'b0;
    cfg_we   = 1'b0;
  endtask

  // Monitor: every presented result is checked against the scoreboard head.
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got data=%0d idx=%0d at cycle %0d, want no output",
                 out_data, out_idx, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (longint'(out_data) != e.data || int'(out_idx) != e.idx ||
            out_last !== e.last || out_err !== e.err || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL result: got data=%0d idx=%0d last=%0b err=%0b cyc=%0d, want data=%0d idx=%0d last=%0b err=%0b cyc=%0d",
                   out_data, out_idx, out_last, out_err, cyc,
                   e.data, e.idx, e.last, e.err, e.cyc);
        end
      end
    end
  end

  longint qtab [13] = '{1068564481, 1069219841, 1070727169, 1071513601, 1072496641,
                        1073479681, 1068433409, 1068236801, 1065811969, 1065484289,
                        1064697857, 1063452673, 1063321601};

  initial begin
    rst      = 1'b0;
    num_mod  = '0;
    a_valid  = 1'b0;
    a_in     = '0;
    b_in     = '0;
    grp_clr  = 1'b0;
    cfg_we   = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;

    // Reset with random inputs, then idle.
    do_reset(3);
    for (int i = 0; i < 10; i++) begin
      idle();
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_valid: got out_valid=%0b, want 0", out_valid);
      end
    end

    // Full-rate rotation over 13 moduli.
    num_mod = (IW+1)'(13);
    for (int i = 0; i < 13; i++) wr(IW'(i), W'(qtab[i]));
    for (int i = 0; i < 39; i++)
      smp(W'($urandom_range(0, 1063321600)), W'($urandom_range(0, 1063321600)), 1'b0);

    // Wrap correction and boundary values, all on table[0].
    smp(W'(5), W'(10), 1'b1);
    smp(W'(10), W'(5), 1'b1);
    smp(W'(0), W'(1068564480), 1'b1);
    smp(W'(1068564480), W'(0), 1'b1);
    smp(W'(777), W'(777), 1'b1);

    // Gaps and grp_clr.
    num_mod = (IW+1)'(6);
    tick(1'b0, '0, '0, 1'b1, 1'b0, '0, '0);
    smp(W'($urandom_range(0, 1000)), W'($urandom_range(0, 1000)), 1'b0);
    idle();
    idle();
    smp(W'($urandom_range(0, 1000)), W'($urandom_range(0, 1000)), 1'b0);
    smp(W'($urandom_range(0, 1000)), W'($urandom_range(0, 1000)), 1'b0);
    smp(W'($urandom_range(0, 1000)), W'($urandom_range(0, 1000)), 1'b1);
    smp(W'($urandom_range(0, 1000)), W'($urandom_range(0, 1000)), 1'b0);

    // Error flag.
    smp(W'(1068564481), W'(0), 1'b1);
    smp(W'(1068564480), W'(0), 1'b1);
    for (int i = 0; i < DLY + 3; i++) idle();

    // Randomized stream: gaps, clears, num_mod changes, live table writes.
    for (int i = 0; i < 400; i++) begin
      bit           av;
      bit           clr;
      bit           we;
      logic [W-1:0] a;
      logic [W-1:0] b;
      if ($urandom_range(0, 24) == 0) num_mod = (IW+1)'($urandom_range(0, 31));
      av  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      we  = ($urandom_range(0, 9) == 0);
      a   = W'($urandom);
      b   = ($urandom_range(0, 7) == 0) ? a : W'($urandom);
      tick(av, a, b, clr, we, IW'($urandom), W'($urandom));
    end
    num_mod = (IW+1)'(6);
    for (int i = 0; i < DLY + 3; i++) idle();

    // Mid-stream reset: in-flight samples must vanish.
    for (int i = 0; i < 5; i++) smp(W'($urandom), W'($urandom), 1'b0);
    do_reset(2);
    wr('0, W'(97));
    smp(W'(3), W'(7), 1'b0);

    for (int i = 0; i < DLY + 6; i++) idle();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d results still outstanding, want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
